smem_wb_stage: RTL and testbench

SMEM_WB_STAGE -- requirements
Module: smem_wb_stage

---
 rtl/smem_wb_stage.sv | 248 ++++++++++++++++++++++++
 tb/tb_smem_wb_stage.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smem_wb_stage.sv
// Purpose: memory/write-back stage; non-memory ops pass straight through, loads and
//          stores run a single outstanding transaction on the data-memory port.
// Latency: non-mem or faulting op 1 cycle after accept; store 1 cycle after grant;
//          load 1 cycle after read data arrives.
// Backpressure: ex_ready_o is high only in IDLE; the request is held until dmem_gnt_i.
// Ports:
//   clk_i, rst_i       - clock, synchronous active-high reset
//   ex_*               - op from execute stage (valid/ready handshake)
//   dmem_*             - data-memory request (req/gnt) and response (rvalid/rdata)
//   wb_*               - registered write-back result, wb_valid_o pulses once per op
module smem_wb_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ex_valid_i,
  input  logic [DATA_WIDTH-1:0] ex_alu_result_i,
  input  logic [DATA_WIDTH-1:0] ex_store_data_i,
  input  logic [31:0]           ex_pc_i,
  input  logic [4:0]            ex_rd_i,
  input  logic                  ex_reg_write_i,
  input  logic [1:0]            ex_result_src_i,
  input  logic                  ex_mem_read_i,
  input  logic                  ex_mem_write_i,
  input  logic [2:0]            ex_funct3_i,
  output logic                  ex_ready_o,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [31:0]           dmem_addr_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  output logic [3:0]            dmem_be_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic                  wb_valid_o,
  output logic [DATA_WIDTH-1:0] wb_alu_result_o,
  output logic [DATA_WIDTH-1:0] wb_mem_rdata_o,
  output logic [31:0]           wb_pc_o,
  output logic [1:0]            wb_result_src_o,
  output logic [4:0]            wb_rd_o,
  output logic                  wb_reg_write_o,
  output logic                  wb_fault_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_t;

  state_t r_state;
  state_t w_state_nxt;

  // captured op
  logic [31:0]           r_addr;
  logic [DATA_WIDTH-1:0] r_sdata;
  logic [31:0]           r_pc;
  logic [4:0]            r_rd;
  logic                  r_reg_write;
  logic [1:0]            r_src;
  logic                  r_we;
  logic [2:0]            r_funct3;

  // write-back registers
  logic                  r_wb_valid;
  logic [DATA_WIDTH-1:0] r_wb_alu;
  logic [DATA_WIDTH-1:0] r_wb_mrd;
  logic [31:0]           r_wb_pc;
  logic [1:0]            r_wb_src;
  logic [4:0]            r_wb_rd;
  logic                  r_wb_reg_write;
  logic                  r_wb_fault;

  logic                  w_accept;
  logic                  w_is_mem;
  logic                  w_f3_ok;
  logic                  w_align_ok;
  logic                  w_legal;
  logic                  w_in_req;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_rdata_sh;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load;

  assign w_accept = ex_valid_i && (r_state == S_IDLE);
  assign w_is_mem = ex_mem_read_i || ex_mem_write_i;

  // Sub-word unsigned encodings (100/101) only exist for loads.
  always_comb begin
    w_f3_ok = 1'b0;
    case (ex_funct3_i)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = !ex_mem_write_i;
      default:                w_f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_align_ok = 1'b1;
    case (ex_funct3_i[1:0])
      2'b01:   w_align_ok = !ex_alu_result_i[0];
      2'b10:   w_align_ok = (ex_alu_result_i[1:0] == 2'b00);
      default: w_align_ok = 1'b1;
    endcase
  end

  assign w_legal = w_f3_ok && w_align_ok;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_mem && w_legal) w_state_nxt = S_REQ;
      S_REQ:   if (dmem_gnt_i) w_state_nxt = r_we ? S_IDLE : S_RSP;
      S_RSP:   if (dmem_rvalid_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Store lane steering: data is replicated so the selected lanes carry it.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_sdata;
    if (r_we) begin
      case (r_funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << r_addr[1:0];
          w_wdata = {4{r_sdata[7:0]}};
        end
        2'b01: begin
          w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{r_sdata[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = r_sdata;
        end
      endcase
    end
  end

  // Request outputs are gated by state so they read zero outside REQ.
  assign w_in_req     = (r_state == S_REQ);
  assign dmem_req_o   = w_in_req;
  assign dmem_we_o    = w_in_req && r_we;
  assign dmem_addr_o  = w_in_req ? {r_addr[31:2], 2'b00} : 32'd0;
  assign dmem_wdata_o = w_in_req ? w_wdata : '0;
  assign dmem_be_o    = w_in_req ? w_be : 4'b0000;
  assign ex_ready_o   = (r_state == S_IDLE);

  // Load data selection and extension.
  assign w_rdata_sh = dmem_rdata_i >> {r_addr[1:0], 3'b000};
  assign w_byte     = w_rdata_sh[7:0];
  assign w_half     = r_addr[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

  always_comb begin
    w_load = dmem_rdata_i;
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= S_IDLE;
      r_addr         <= '0;
      r_sdata        <= '0;
      r_pc           <= '0;
      r_rd           <= '0;
      r_reg_write    <= 1'b0;
      r_src          <= '0;
      r_we           <= 1'b0;
      r_funct3       <= '0;
      r_wb_valid     <= 1'b0;
      r_wb_alu       <= '0;
      r_wb_mrd       <= '0;
      r_wb_pc        <= '0;
      r_wb_src       <= '0;
      r_wb_rd        <= '0;
      r_wb_reg_write <= 1'b0;
      r_wb_fault     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wb_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr      <= ex_alu_result_i;
            r_sdata     <= ex_store_data_i;
            r_pc        <= ex_pc_i;
            r_rd        <= ex_rd_i;
            r_reg_write <= ex_reg_write_i;
            r_src       <= ex_result_src_i;
            r_we        <= ex_mem_write_i;
            r_funct3    <= ex_funct3_i;
            // Pass-through and faulting ops retire straight away.
            if (!w_is_mem || !w_legal) begin
              r_wb_valid     <= 1'b1;
              r_wb_alu       <= ex_alu_result_i;
              r_wb_mrd       <= '0;
              r_wb_pc        <= ex_pc_i;
              r_wb_src       <= ex_result_src_i;
              r_wb_rd        <= ex_rd_i;
              r_wb_reg_write <= w_is_mem ? 1'b0 : ex_reg_write_i;
              r_wb_fault     <= w_is_mem;
            end
          end
        end
        S_REQ: begin
          if (dmem_gnt_i && r_we) begin
            r_wb_valid     <= 1'b1;
            r_wb_alu       <= r_addr;
            r_wb_mrd       <= '0;
            r_wb_pc        <= r_pc;
            r_wb_src       <= r_src;
            r_wb_rd        <= r_rd;
            r_wb_reg_write <= 1'b0;
            r_wb_fault     <= 1'b0;
          end
        end
        S_RSP: begin
          if (dmem_rvalid_i) begin
            r_wb_valid     <= 1'b1;
            r_wb_alu       <= r_addr;
            r_wb_mrd       <= w_load;
            r_wb_pc        <= r_pc;
            r_wb_src       <= r_src;
            r_wb_rd        <= r_rd;
            r_wb_reg_write <= r_reg_write;
            r_wb_fault     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign wb_valid_o      = r_wb_valid;
  assign wb_alu_result_o = r_wb_alu;
  assign wb_mem_rdata_o  = r_wb_mrd;
  assign wb_pc_o         = r_wb_pc;
  assign wb_result_src_o = r_wb_src;
  assign wb_rd_o         = r_wb_rd;
  assign wb_reg_write_o  = r_wb_reg_write;
  assign wb_fault_o      = r_wb_fault;

endmodule

// File: tb/tb_smem_wb_stage.sv
module tb_smem_wb_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_valid_i;
  logic [31:0] ex_alu_result_i, ex_store_data_i, ex_pc_i;
  logic [4:0]  ex_rd_i;
  logic        ex_reg_write_i;
  logic [1:0]  ex_result_src_i;
  logic        ex_mem_read_i, ex_mem_write_i;
  logic [2:0]  ex_funct3_i;
  logic        ex_ready_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic [31:0] wb_alu_result_o, wb_mem_rdata_o, wb_pc_o;
  logic [1:0]  wb_result_src_o;
  logic [4:0]  wb_rd_o;
  logic        wb_reg_write_o, wb_fault_o;

  smem_wb_stage #(.DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ex_valid_i(ex_valid_i), .ex_alu_result_i(ex_alu_result_i),
    .ex_store_data_i(ex_store_data_i), .ex_pc_i(ex_pc_i), .ex_rd_i(ex_rd_i),
    .ex_reg_write_i(ex_reg_write_i), .ex_result_src_i(ex_result_src_i),
    .ex_mem_read_i(ex_mem_read_i), .ex_mem_write_i(ex_mem_write_i),
    .ex_funct3_i(ex_funct3_i), .ex_ready_o(ex_ready_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_alu_result_o(wb_alu_result_o),
    .wb_mem_rdata_o(wb_mem_rdata_o), .wb_pc_o(wb_pc_o),
    .wb_result_src_o(wb_result_src_o), .wb_rd_o(wb_rd_o),
    .wb_reg_write_o(wb_reg_write_o), .wb_fault_o(wb_fault_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          cyc;
    logic [31:0] alu, mrd, pc;
    logic [1:0]  src;
    logic [4:0]  rd;
    logic        rw, flt;
  } wb_t;

  wb_t q[$];
  wb_t last;
  wb_t zero_wb;

  int n_err = 0, n_chk = 0;
  int ncyc = 0;
  int req_seen = 0;
  logic chk_en = 1'b0;
  logic exp_busy = 1'b0, exp_req = 1'b0, exp_we = 1'b0;
  logic [31:0] exp_addr = 0, exp_wdata = 0;
  logic [3:0]  exp_be = 0;
  logic [31:0] cap_addr = 0, cap_wdata = 0;
  logic [3:0]  cap_be = 0;
  logic        cap_we = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_wb(input wb_t e);
    chk("wb_alu_result", wb_alu_result_o, e.alu);
    chk("wb_mem_rdata", wb_mem_rdata_o, e.mrd);
    chk("wb_pc", wb_pc_o, e.pc);
    chk("wb_result_src", 32'(wb_result_src_o), 32'(e.src));
    chk("wb_rd", 32'(wb_rd_o), 32'(e.rd));
    chk("wb_reg_write", 32'(wb_reg_write_o), 32'(e.rw));
    chk("wb_fault", 32'(wb_fault_o), 32'(e.flt));
  endtask

  // ---------------- behavioural model of the access rules ----------------
  function automatic logic m_legal(input logic mw, input logic [2:0] f3, input logic [31:0] a);
    logic ok;
    ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!mw && (f3 == 3'd4 || f3 == 3'd5));
    if (f3[1:0] == 2'd1 && (a % 2) != 0) ok = 1'b0;
    if (f3[1:0] == 2'd2 && (a % 4) != 0) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [3:0] m_be(input logic mw, input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] t;
    if (!mw) return 4'hF;
    if (f3[1:0] == 2'd0) begin
      t = 32'd1 << (a % 4);
      return t[3:0];
    end
    if (f3[1:0] == 2'd1) return ((a % 4) >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3[1:0] == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (f3[1:0] == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * (a % 4))) & 32'hFF;
    h = (d >> (16 * ((a % 4) / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_i) begin
    wb_t e;
    ncyc++;
    if (chk_en) begin
      chk("ex_ready", 32'(ex_ready_o), 32'(!exp_busy));
      chk("dmem_req", 32'(dmem_req_o), 32'(exp_req));
      if (exp_req) begin
        chk("dmem_addr", dmem_addr_o, exp_addr);
        chk("dmem_we", 32'(dmem_we_o), 32'(exp_we));
        chk("dmem_be", 32'(dmem_be_o), 32'(exp_be));
        if (exp_we) chk("dmem_wdata", dmem_wdata_o, exp_wdata);
      end
      if (dmem_req_o) begin
        req_seen++;
        cap_addr  = dmem_addr_o;
        cap_wdata = dmem_wdata_o;
        cap_be    = dmem_be_o;
        cap_we    = dmem_we_o;
      end
      if (q.size() > 0 && q[0].cyc == ncyc) begin
        e = q.pop_front();
        chk("wb_valid_pulse", 32'(wb_valid_o), 32'd1);
        chk_wb(e);
        last = e;
      end else begin
        chk("wb_valid_idle", 32'(wb_valid_o), 32'd0);
        chk_wb(last);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Must be called just after a rising edge.
  task automatic do_op(input logic mr, input logic mw, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] pc,
                       input logic [4:0] rd, input logic rw, input logic [1:0] src,
                       input int gw, input int rsw, input logic [31:0] rdat);
    wb_t e;
    int t;
    ex_valid_i = 1'b1; ex_alu_result_i = addr; ex_store_data_i = sd; ex_pc_i = pc;
    ex_rd_i = rd; ex_reg_write_i = rw; ex_result_src_i = src;
    ex_mem_read_i = mr; ex_mem_write_i = mw; ex_funct3_i = f3;
    t = 0;
    while (!ex_ready_o && t < 50) begin step(); t++; end
    if (!ex_ready_o) begin
      chk("accept_timeout", 32'd0, 32'd1);
      ex_valid_i = 1'b0;
      return;
    end
    step();  // accept edge
    ex_valid_i = 1'b0;
    ex_alu_result_i = $urandom; ex_store_data_i = $urandom; ex_pc_i = $urandom;
    ex_mem_read_i = $urandom_range(0, 1); ex_mem_write_i = $urandom_range(0, 1);
    e.alu = addr; e.pc = pc; e.src = src; e.rd = rd; e.mrd = 32'd0; e.flt = 1'b0; e.rw = rw;
    if (!(mr || mw)) begin
      e.cyc = ncyc + 1; q.push_back(e); return;
    end
    if (!m_legal(mw, f3, addr)) begin
      e.flt = 1'b1; e.rw = 1'b0; e.cyc = ncyc + 1; q.push_back(e); return;
    end
    exp_busy = 1'b1; exp_req = 1'b1;
    exp_addr = addr & 32'hFFFF_FFFC; exp_we = mw;
    exp_be = m_be(mw, f3, addr); exp_wdata = m_wdata(f3, sd);
    for (int i = 0; i < gw; i++) begin
      dmem_rvalid_i = $urandom_range(0, 1);  // must be ignored outside RSP
      dmem_rdata_i  = $urandom;
      step();
    end
    dmem_rvalid_i = 1'b0;
    dmem_gnt_i = 1'b1;
    step();  // grant edge
    dmem_gnt_i = 1'b0;
    exp_req = 1'b0;
    if (mw) begin
      exp_busy = 1'b0; e.rw = 1'b0; e.cyc = ncyc + 1; q.push_back(e); return;
    end
    for (int i = 0; i < rsw; i++) step();
    dmem_rvalid_i = 1'b1; dmem_rdata_i = rdat;
    step();  // response edge
    dmem_rvalid_i = 1'b0; dmem_rdata_i = $urandom;
    exp_busy = 1'b0;
    e.mrd = m_load(f3, addr, rdat);
    e.cyc = ncyc + 1; q.push_back(e);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    int s;
    logic mr, mw;
    logic [2:0] f3;
    logic [31:0] a;
    int kind;

    zero_wb = '{cyc: 0, alu: 0, mrd: 0, pc: 0, src: 0, rd: 0, rw: 0, flt: 0};
    last = zero_wb;
    rst_i = 1'b1; ex_valid_i = 1'b0; ex_alu_result_i = 0; ex_store_data_i = 0; ex_pc_i = 0;
    ex_rd_i = 0; ex_reg_write_i = 0; ex_result_src_i = 0; ex_mem_read_i = 0;
    ex_mem_write_i = 0; ex_funct3_i = 0; dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
    step();
    chk_en = 1'b1;
    step(); step();
    rst_i = 1'b0;
    chk("rst_ready", 32'(ex_ready_o), 32'd1);
    chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst_dmem_addr", dmem_addr_o, 32'd0);
    chk("rst_wb_pc", wb_pc_o, 32'd0);

    // back-to-back pass-through ops
    do_op(0, 0, 3'd0, 32'h100, 0, 32'h100, 5'd1, 1, 2'd0, 0, 0, 0);
    do_op(0, 0, 3'd0, 32'h104, 0, 32'h104, 5'd2, 1, 2'd1, 0, 0, 0);
    do_op(0, 0, 3'd0, 32'h108, 0, 32'h108, 5'd3, 1, 2'd2, 0, 0, 0);
    @(negedge clk_i);
    chk("nm3_pc", wb_pc_o, 32'h108);
    chk("nm3_valid", 32'(wb_valid_o), 32'd1);
    step();

    // LB / LBU at 0x1003
    do_op(1, 0, 3'd0, 32'h1003, 0, 32'h200, 5'd5, 1, 2'd1, 2, 1, 32'h80FF_1234);
    @(negedge clk_i);
    chk("lb_rdata", wb_mem_rdata_o, 32'hFFFF_FF80);
    chk("lb_addr", cap_addr, 32'h1000);
    step();
    do_op(1, 0, 3'd4, 32'h1003, 0, 32'h204, 5'd6, 1, 2'd1, 2, 1, 32'h80FF_1234);
    @(negedge clk_i);
    chk("lbu_rdata", wb_mem_rdata_o, 32'h0000_0080);
    step();

    // SH at 0x2002
    do_op(0, 1, 3'd1, 32'h2002, 32'h0000_ABCD, 32'h208, 5'd7, 1, 2'd0, 1, 0, 0);
    @(negedge clk_i);
    chk("sh_be", 32'(cap_be), 32'hC);
    chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    chk("sh_we", 32'(cap_we), 32'd1);
    chk("sh_reg_write", 32'(wb_reg_write_o), 32'd0);
    step();

    // misaligned LW and illegal funct3 load
    s = req_seen;
    do_op(1, 0, 3'd2, 32'h3001, 0, 32'h20C, 5'd8, 1, 2'd1, 0, 0, 0);
    @(negedge clk_i);
    chk("lw_mis_fault", 32'(wb_fault_o), 32'd1);
    chk("lw_mis_rw", 32'(wb_reg_write_o), 32'd0);
    step();
    do_op(1, 0, 3'd6, 32'h3000, 0, 32'h210, 5'd9, 1, 2'd1, 0, 0, 0);
    @(negedge clk_i);
    chk("f3_110_fault", 32'(wb_fault_o), 32'd1);
    chk("fault_no_req", 32'(req_seen), 32'(s));
    step();

    // reset while waiting in RSP, then a late rvalid
    ex_valid_i = 1'b1; ex_alu_result_i = 32'h4000; ex_pc_i = 32'h300; ex_rd_i = 5'd10;
    ex_reg_write_i = 1'b1; ex_result_src_i = 2'd1; ex_mem_read_i = 1'b1;
    ex_mem_write_i = 1'b0; ex_funct3_i = 3'd2;
    step();
    ex_valid_i = 1'b0; ex_mem_read_i = 1'b0;
    exp_busy = 1'b1; exp_req = 1'b1; exp_addr = 32'h4000; exp_we = 1'b0; exp_be = 4'hF;
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0; exp_req = 1'b0;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0; exp_busy = 1'b0; last = zero_wb;
    chk("rsp_rst_ready", 32'(ex_ready_o), 32'd1);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
    step();
    dmem_rvalid_i = 1'b0;
    chk("late_rvalid_no_wb", 32'(wb_valid_o), 32'd0);
    do_op(1, 0, 3'd5, 32'h4002, 0, 32'h304, 5'd11, 1, 2'd1, 0, 0, 32'h8765_4321);
    @(negedge clk_i);
    chk("post_rst_lhu", wb_mem_rdata_o, 32'h0000_8765);
    step();

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      mr = (kind >= 4 && kind <= 6);
      mw = (kind >= 7);
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else if (mw) f3 = 3'($urandom_range(0, 2));
      else f3 = ld_f3[$urandom_range(0, 4)];
      a = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        if (f3[1:0] == 2'd1) a[0] = 1'b0;
        if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
      end
      do_op(mr, mw, f3, a, $urandom, $urandom, 5'($urandom), 1'($urandom),
            2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 3) == 0) step();
    end

    repeat (4) step();
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
